// File: rtl/switch_calc_bcd_engine.sv
// switch_calc_bcd_engine: switch operands, debounced calculate button, add/|A-B| and a serial double-dabble BCD result
module switch_calc_bcd_engine #(
    parameter int OP_WIDTH        = 7,
    parameter int OP_MAX          = 99,
    parameter int OP_DIGITS       = 2,
    parameter int RES_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_WIDTH-1:0]     switchs,
    input  logic                    switch_mode,
    input  logic                    switch_cal,
    input  logic                    op_sub,
    output logic [4*OP_DIGITS-1:0]  a_bcd,
    output logic [4*OP_DIGITS-1:0]  b_bcd,
    output logic [4*RES_DIGITS-1:0] result_bcd,
    output logic                    result_neg,
    output logic                    busy,
    output logic                    done
);
    localparam int RES_W = OP_WIDTH + 1;
    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW    = $clog2(RES_W + 1);
    localparam logic [OP_WIDTH-1:0] MAX_V     = OP_WIDTH'(OP_MAX);
    localparam logic [CW-1:0]       DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]       DB_FULL   = CW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0]       STEP_LAST = SW'(RES_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

    state_t                  r_state;
    logic [1:0]              r_sync;
    logic [CW-1:0]           r_cnt;
    logic                    r_evt;
    logic [OP_WIDTH-1:0]     r_a;
    logic [OP_WIDTH-1:0]     r_b;
    logic                    r_sub;
    logic                    r_neg;
    logic [RES_W-1:0]        r_bin;
    logic [4*RES_DIGITS-1:0] r_bcd;
    logic [SW-1:0]           r_step;
    logic [OP_WIDTH-1:0]     w_sat;
    logic [4*RES_DIGITS-1:0] w_adj;

    function automatic logic [4*OP_DIGITS-1:0] to_bcd(input logic [OP_WIDTH-1:0] v);
        logic [OP_WIDTH-1:0] t;
        to_bcd = '0;
        t = v;
        for (int i = 0; i < OP_DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(t % 10);
            t = OP_WIDTH'(t / 10);
        end
    endfunction

    assign w_sat = (switchs > MAX_V) ? MAX_V : switchs;

    // Counter saturates at DEBOUNCE_CYCLES so a held button yields a single event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_evt  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], switch_cal};
            r_cnt  <= !r_sync[1] ? '0 : (r_cnt == DB_FULL ? r_cnt : r_cnt + 1'b1);
            r_evt  <= r_sync[1] && r_cnt == DB_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            a_bcd <= '0;
            b_bcd <= '0;
        end else begin
            if (!busy && switch_mode) r_a <= w_sat;
            if (!busy && !switch_mode) r_b <= w_sat;
            a_bcd <= to_bcd(r_a);
            b_bcd <= to_bcd(r_b);
        end
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < RES_DIGITS; i++)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sub      <= 1'b0;
            r_neg      <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            result_bcd <= '0;
            result_neg <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (r_evt) begin
                    r_sub   <= op_sub;
                    busy    <= 1'b1;
                    r_state <= CALC;
                end
                CALC: begin
                    r_neg   <= r_sub && r_a < r_b;
                    r_bin   <= !r_sub ? {1'b0, r_a} + {1'b0, r_b}
                             : (r_a < r_b ? {1'b0, r_b - r_a} : {1'b0, r_a - r_b});
                    r_bcd   <= '0;
                    r_step  <= '0;
                    r_state <= CONV;
                end
                CONV: begin
                    {r_bcd, r_bin} <= {w_adj[4*RES_DIGITS-2:0], r_bin, 1'b0};
                    r_step         <= r_step + 1'b1;
                    if (r_step == STEP_LAST) r_state <= DONE;
                end
                DONE: begin
                    result_bcd <= r_bcd;
                    result_neg <= r_neg;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule
